data_memory_responder: RTL

- Memory-side responder for the pipelined processor's instruction and data ports.
- Serves instruction fetches from InstrAddr with fixed 1-cycle latency.
- Serves data reads and writes requested on DataAddr/ReadData/WriteData, and signals completion on DataDone after a programmable latency.
- Port names mirror the processor's names so the two blocks connect by name at top level.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/memory_array.sv | 36 +++
 rtl/data_memory_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the data memory responder
package mem_pkg;

    localparam int WORD_SIZE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } MemState;

    typedef struct packed {
        logic [WORD_SIZE_DEF-1:0] addr;
        logic [WORD_SIZE_DEF-1:0] wdata;
        logic                     is_write;
    } MemReq;

    function automatic logic addr_ok(input logic [WORD_SIZE_DEF-1:0] addr, input int depth);
        logic [31:0] a32;
        a32 = 32'(addr);
        return a32 < $unsigned(depth);
    endfunction

endpackage

// File: rtl/memory_array.sv
// rtl/memory_array.sv - DEPTH x WORD_SIZE synchronous RAM, instruction read port plus data read/write port
module memory_array #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 256,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic [AW-1:0]        instr_addr_i,
    output logic [WORD_SIZE-1:0] instr_rdata_o,
    input  logic                 data_en_i,
    input  logic                 data_we_i,
    input  logic [AW-1:0]        data_addr_i,
    input  logic [WORD_SIZE-1:0] data_wdata_i,
    output logic [WORD_SIZE-1:0] data_rdata_o
);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [WORD_SIZE-1:0] instr_rdata_q;
    logic [WORD_SIZE-1:0] data_rdata_q;

    // Read-before-write: a same-edge instruction fetch of the written word sees the old value.
    always_ff @(posedge clk_i) begin
        instr_rdata_q <= mem_q[instr_addr_i];
        if (data_en_i) begin
            if (data_we_i) begin
                mem_q[data_addr_i] <= data_wdata_i;
            end else begin
                data_rdata_q <= mem_q[data_addr_i];
            end
        end
    end

    assign instr_rdata_o = instr_rdata_q;
    assign data_rdata_o  = data_rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - instruction/data memory responder with programmable data latency
// Optional ReadCount/WriteCount counters enabled by MEM_PERF_COUNTERS_EN.
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 1
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    output logic [WORD_SIZE-1:0] InstrIn,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic                 ReadData,
    input  logic                 WriteData,
    input  logic [WORD_SIZE-1:0] DataOut,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 Busy,
    output logic                 AddrErr,
    output logic [15:0]          ReadCount,
    output logic [15:0]          WriteCount
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    MemState              state_q;
    logic [3:0]           cnt_q;
    MemReq                req_q;
    logic                 instr_ok_q;
    logic                 data_ok_q;
    logic                 addr_err_q;

    logic                 accept;
    logic                 go_resp;
    logic                 instr_ok;
    logic                 op_ok;
    MemReq                new_req;
    MemReq                op;
    logic [WORD_SIZE-1:0] ram_instr;
    logic [WORD_SIZE-1:0] ram_data;

    assign accept   = (state_q != WAIT) && (ReadData || WriteData);
    assign new_req  = '{addr: DataAddr, wdata: DataOut, is_write: WriteData};
    // With LATENCY=1 the access happens on the acceptance edge, so it uses the live request.
    assign go_resp  = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 4'd1));
    assign op       = (state_q == WAIT) ? req_q : new_req;
    assign op_ok    = addr_ok(op.addr, DEPTH);
    assign instr_ok = addr_ok(InstrAddr, DEPTH);

    memory_array #(
        .WORD_SIZE(WORD_SIZE),
        .DEPTH    (DEPTH)
    ) u_mem (
        .clk_i        (Clock),
        .instr_addr_i (InstrAddr[AW-1:0]),
        .instr_rdata_o(ram_instr),
        .data_en_i    (go_resp && op_ok),
        .data_we_i    (op.is_write),
        .data_addr_i  (op.addr[AW-1:0]),
        .data_wdata_i (op.wdata),
        .data_rdata_o (ram_data)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            req_q      <= '0;
            instr_ok_q <= 1'b0;
            data_ok_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            instr_ok_q <= instr_ok;
            if (!instr_ok || (go_resp && !op_ok)) begin
                addr_err_q <= 1'b1;
            end
            // RAM read register is unreset; this flag masks it until a valid read lands.
            if (go_resp && !op.is_write) begin
                data_ok_q <= op_ok;
            end
            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        req_q   <= new_req;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign InstrIn  = instr_ok_q ? ram_instr : '0;
    assign DataIn   = data_ok_q ? ram_data : '0;
    assign DataDone = (state_q == RESP);
    assign Busy     = (state_q == WAIT);
    assign AddrErr  = addr_err_q;

`ifdef MEM_PERF_COUNTERS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (go_resp) begin
            if (op.is_write) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign ReadCount  = rd_cnt_q;
    assign WriteCount = wr_cnt_q;
`else
    assign ReadCount  = 16'd0;
    assign WriteCount = 16'd0;
`endif

endmodule
